// File: rtl/plot_framebuffer_sink_if.sv
// Plot bus from the game logic into the framebuffer sink: one pixel write per
// asserted plot_en clock, plus a single-clock request to clear the buffer.
interface plot_framebuffer_sink_if;
  logic       plot_en;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       clear_req;

  modport master (output plot_en, x, y, colour, clear_req);
  modport slave  (input  plot_en, x, y, colour, clear_req);
endinterface

// File: rtl/plot_framebuffer_sink.sv
// 160x120x3 framebuffer fed by the plot bus, with a background clear engine and
// a 640x480@60 VGA scan-out that repeats every stored pixel 4x4 on screen.
module plot_framebuffer_sink #(
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  plot_framebuffer_sink_if.slave  i_plot,
  output logic                    busy,
  output logic [7:0]              drop_count,
  output logic [2:0]              vga_colour,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n,
  output logic                    frame_start
);
  localparam int unsigned FB_WORDS  = 19200;
  localparam logic [14:0] LAST_ADDR = 15'(FB_WORDS - 1);
  localparam logic [9:0]  H_LAST    = 10'd799;
  localparam logic [9:0]  V_LAST    = 10'd524;
  localparam logic [9:0]  H_VIS     = 10'd640;
  localparam logic [9:0]  V_VIS     = 10'd480;

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t      r_state;
  logic [14:0] r_clear_addr;
  logic [7:0]  r_drop_count;
  logic        r_pix_tick;
  logic [9:0]  r_h_count;
  logic [9:0]  r_v_count;
  logic [2:0]  r_rd_data;
  logic [2:0]  r_vga_colour;
  logic        r_vga_hs;
  logic        r_vga_vs;
  logic        r_vga_blank_n;
  logic        r_frame_start;
  logic [2:0]  r_fb [0:FB_WORDS-1];

  logic        w_in_range;
  logic [14:0] w_plot_addr;
  logic        w_we;
  logic [14:0] w_wr_addr;
  logic [2:0]  w_wr_data;
  logic        w_drop;
  logic        w_visible;
  logic [14:0] w_rd_addr;

  // y*160 + x as two shifted copies of y plus x.
  assign w_in_range  = (i_plot.x < 8'd160) && (i_plot.y < 7'd120);
  assign w_plot_addr = {1'b0, i_plot.y, 7'b0} + {3'b0, i_plot.y, 5'b0} + {7'b0, i_plot.x};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_we      = 1'b0;
    w_wr_addr = w_plot_addr;
    w_wr_data = i_plot.colour;
    w_drop    = 1'b0;
    if (r_state == ST_CLEAR) begin
      w_we      = 1'b1;
      w_wr_addr = r_clear_addr;
      w_wr_data = BG_COLOUR;
      w_drop    = i_plot.plot_en;
    end else begin
      w_we   = i_plot.plot_en && w_in_range;
      w_drop = i_plot.plot_en && !w_in_range;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clear_addr <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_drop && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
      case (r_state)
        ST_RUN: begin
          // A plot in the same clock as clear_req has already been written above.
          if (i_plot.clear_req) begin
            r_state      <= ST_CLEAR;
            r_clear_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clear_addr == LAST_ADDR) begin
            r_state      <= ST_RUN;
            r_clear_addr <= '0;
          end else begin
            r_clear_addr <= r_clear_addr + 15'd1;
          end
        end
      endcase
    end
  end

  assign busy       = (r_state == ST_CLEAR);
  assign drop_count = r_drop_count;

  assign w_visible = (r_h_count < H_VIS) && (r_v_count < V_VIS);
  assign w_rd_addr = w_visible
                   ? ({1'b0, r_v_count[8:2], 7'b0} + {3'b0, r_v_count[8:2], 5'b0} + {7'b0, r_h_count[9:2]})
                   : '0;

  // NOTE: the framebuffer has no reset; the clear engine is what gives it known contents.
  always_ff @(posedge clock) begin
    if (w_we)
      r_fb[w_wr_addr] <= w_wr_data;
    r_rd_data <= r_fb[w_rd_addr];
  end

  // Outputs load on tick clocks from the counters that addressed r_rd_data on the
  // previous clock, so every output lags the counters by one pixel and stays aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pix_tick    <= 1'b0;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_vga_colour  <= '0;
      r_vga_hs      <= 1'b1;
      r_vga_vs      <= 1'b1;
      r_vga_blank_n <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_tick    <= ~r_pix_tick;
      r_frame_start <= 1'b0;
      if (r_pix_tick) begin
        r_vga_colour  <= w_visible ? r_rd_data : 3'b000;
        r_vga_hs      <= !((r_h_count >= 10'd656) && (r_h_count <= 10'd751));
        r_vga_vs      <= !((r_v_count >= 10'd490) && (r_v_count <= 10'd491));
        r_vga_blank_n <= w_visible;
        r_frame_start <= (r_h_count == 10'd0) && (r_v_count == 10'd0);
        if (r_h_count == H_LAST) begin
          r_h_count <= '0;
          r_v_count <= (r_v_count == V_LAST) ? 10'd0 : r_v_count + 10'd1;
        end else begin
          r_h_count <= r_h_count + 10'd1;
        end
      end
    end
  end

  assign vga_colour  = r_vga_colour;
  assign vga_hs      = r_vga_hs;
  assign vga_vs      = r_vga_vs;
  assign vga_blank_n = r_vga_blank_n;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_plot_framebuffer_sink.sv
// Bench for plot_framebuffer_sink: a reference model predicts every clock's outputs
// from elapsed time and a pixel array; a monitor pops and compares them at negedge.
module tb_plot_framebuffer_sink;
  localparam logic [2:0] BG       = 3'b000;
  localparam int         FB_WORDS = 19200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [7:0] drop_count;
  logic [2:0] vga_colour;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       frame_start;

  plot_framebuffer_sink_if u_if ();

  plot_framebuffer_sink #(.BG_COLOUR(BG), .CLEAR_ON_RESET(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_plot      (u_if),
    .busy        (busy),
    .drop_count  (drop_count),
    .vga_colour  (vga_colour),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       busy;
    logic [7:0] drop;
    logic [2:0] colour;
    logic       col_known;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model: time since reset, clear progress, drops, and the pixel array.
  int         m_t = 0;
  bit         m_clearing = 1'b1;
  int         m_k = 0;
  int         m_drops = 0;
  logic [2:0] m_fb [FB_WORDS];
  bit         m_known [FB_WORDS];
  int         m_lw [FB_WORDS];
  exp_t       m_last;

  initial begin
    for (int i = 0; i < FB_WORDS; i++) m_lw[i] = -10;
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0d)", name, got, want, m_t);
    end
  endtask

  // Pixel p is shown from clock 2p+2; its colour was read at clock 2p+1, so a
  // write to the same word at that clock may or may not be visible.
  always @(posedge clock) begin : predictor
    exp_t e;
    int   p, h, v, a;
    if (reset) begin
      m_t = 0; m_clearing = 1'b1; m_k = 0; m_drops = 0;
      e.colour = 3'b000; e.col_known = 1'b1; e.hs = 1'b1; e.vs = 1'b1;
      e.blank_n = 1'b0; e.fs = 1'b0;
    end else begin
      m_t++;
      e = m_last;
      e.fs = 1'b0;
      if (m_t % 2 == 0) begin
        p = m_t / 2 - 1;
        h = p % 800;
        v = (p / 800) % 525;
        e.hs      = !(h >= 656 && h <= 751);
        e.vs      = !(v >= 490 && v <= 491);
        e.blank_n = (h < 640) && (v < 480);
        e.fs      = (h == 0) && (v == 0);
        e.colour    = 3'b000;
        e.col_known = 1'b1;
        if (e.blank_n) begin
          a = (v / 4) * 160 + h / 4;
          e.colour    = m_fb[a];
          e.col_known = m_known[a] && (m_lw[a] != m_t - 1);
        end
      end
      if (m_clearing) begin
        m_fb[m_k] = BG; m_known[m_k] = 1'b1; m_lw[m_k] = m_t;
        if (u_if.plot_en && m_drops < 255) m_drops++;
        if (m_k == FB_WORDS - 1) m_clearing = 1'b0;
        else m_k++;
      end else begin
        if (u_if.plot_en) begin
          if (u_if.x < 160 && u_if.y < 120) begin
            a = u_if.y * 160 + u_if.x;
            m_fb[a] = u_if.colour; m_known[a] = 1'b1; m_lw[a] = m_t;
          end else if (m_drops < 255) begin
            m_drops++;
          end
        end
        if (u_if.clear_req) begin
          m_clearing = 1'b1; m_k = 0;
        end
      end
    end
    e.busy = m_clearing;
    e.drop = m_drops[7:0];
    m_last = e;
    exp_q.push_back(e);
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (busy !== e.busy || drop_count !== e.drop || vga_hs !== e.hs || vga_vs !== e.vs ||
          vga_blank_n !== e.blank_n || frame_start !== e.fs ||
          (e.col_known && vga_colour !== e.colour)) begin
        n_bad++;
        $display("FAIL scan t=%0d: got busy=%b drop=%0d col=%b hs=%b vs=%b blank_n=%b fs=%b; want busy=%b drop=%0d col=%b(known=%b) hs=%b vs=%b blank_n=%b fs=%b",
                 m_t, busy, drop_count, vga_colour, vga_hs, vga_vs, vga_blank_n, frame_start,
                 e.busy, e.drop, e.colour, e.col_known, e.hs, e.vs, e.blank_n, e.fs);
      end
    end
  end

  task automatic idle();
    u_if.plot_en   = 1'b0;
    u_if.clear_req = 1'b0;
  endtask

  task automatic drive_plot(input int xx, input int yy, input logic [2:0] c);
    u_if.plot_en = 1'b1;
    u_if.x       = 8'(xx);
    u_if.y       = 7'(yy);
    u_if.colour  = c;
  endtask

  // Counts clocks with busy high starting from the current sample; optionally
  // issues a plot and a clear_req at given offsets while the clear runs.
  task automatic count_busy(input int plot_at, input int req_at, output int n, output bit timed_out);
    n = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      n++;
      idle();
      if (i == plot_at) drive_plot(11, 10, 3'b101);
      if (i == req_at) u_if.clear_req = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: bench did not finish (t=%0d)", m_t);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, cnt, xx, yy;
    bit to;
    idle();
    u_if.x = '0; u_if.y = '0; u_if.colour = '0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    // First clear: plots during it are dropped, then reset aborts it at clock 5000.
    repeat (100) @(negedge clock);
    drive_plot(1, 1, 3'b111);
    repeat (3) @(negedge clock);
    idle();
    @(negedge clock);
    check("drop_during_clear", drop_count, 3);
    while (m_t < 5000) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("rst_busy", busy, 1);
    check("rst_drop", drop_count, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank_n", vga_blank_n, 0);
    check("rst_frame_start", frame_start, 0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    count_busy(-1, -1, n, to);
    check("clear_after_reset_timeout", to, 0);
    check("clear_after_reset_len", n, 19200);

    // Single pixel (5,3) shows as a 4x4 block at h=20..23, v=12..15.
    drive_plot(5, 3, 3'b110);
    @(negedge clock);
    idle();
    cnt = 0;
    while (m_t < 25700) begin
      if (vga_blank_n && vga_colour == 3'b110) cnt++;
      @(negedge clock);
    end
    check("pixel_5_3_clocks", cnt, 32);
    check("drop_after_clear", drop_count, 0);

    drive_plot(160, 0, 3'b111);
    @(negedge clock);
    drive_plot(0, 120, 3'b111);
    @(negedge clock);
    idle();
    @(negedge clock);
    check("drop_two_oor", drop_count, 2);

    // Plot and clear_req together, a dropped plot 5 clocks later, a clear_req mid-clear.
    drive_plot(10, 10, 3'b011);
    u_if.clear_req = 1'b1;
    @(negedge clock);
    count_busy(4, 1000, n, to);
    check("clear_req_timeout", to, 0);
    check("clear_req_len", n, 19200);
    check("drop_plot_in_clear", drop_count, 3);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        xx = 160 + $urandom_range(0, 95); yy = $urandom_range(0, 127);
      end else begin
        xx = $urandom_range(0, 255); yy = 120 + $urandom_range(0, 7);
      end
      drive_plot(xx, yy, 3'($urandom_range(0, 7)));
      @(negedge clock);
    end
    idle();
    @(negedge clock);
    check("drop_saturated", drop_count, 255);

    // Random plots into rows 8..10 (scanned later in this frame), keeping (10,10) and (11,10) cleared.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        xx = $urandom_range(0, 255); yy = $urandom_range(120, 127);
      end else begin
        yy = $urandom_range(8, 10); xx = $urandom_range(0, 159);
        if (yy == 10 && (xx == 10 || xx == 11)) xx = 12;
      end
      drive_plot(xx, yy, 3'($urandom_range(0, 7)));
      u_if.plot_en = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    idle();

    cnt = 0;
    repeat (1600) begin
      if (!vga_hs) cnt++;
      @(negedge clock);
    end
    check("hs_low_per_line", cnt, 192);

    while (m_t < 70500) @(negedge clock);
    check("drop_final", drop_count, 255);
    check("busy_final", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/plot_framebuffer_sink.md
Name: plot_framebuffer_sink

Overview:
- Receiving end of the game's plot interface (plot_en/x/y/colour).
- Stores each plotted pixel in an on-chip 160x120x3-bit framebuffer.
- Continuously scans the framebuffer out as 640x480@60 VGA, with each stored pixel repeated 4x4 on screen.
- Includes a clear engine that fills the buffer with a background colour after reset and on request.

Parameters:
- BG_COLOUR, 3'b000, colour written by the clear engine.
- CLEAR_ON_RESET, 1, 1 = enter CLEAR after reset; 0 = enter RUN directly.

Ports:
- clock  in  1  system clock (50 MHz nominal).
- reset  in  1  asynchronous, active-high reset.
- plot_en  in  1  write strobe, one pixel per asserted clock.
- x  in  8  pixel column.
- y  in  7  pixel row.
- colour  in  3  pixel colour {R,G,B}.
- clear_req  in  1  single-clock request to clear the framebuffer.
- busy  out  1  high while in CLEAR.
- drop_count  out  8  saturating count of plots not written.
- vga_colour  out  3  scanned-out colour.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  high in the visible region.
- frame_start  out  1  one-clock pulse when pixel (0,0) is presented.

Behaviour:
- Reset: one clock and an asynchronous, active-high reset.
  - Async reset values: vga_colour=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0, drop_count=0, busy=CLEAR_ON_RESET, pix_tick=0, h_count=0, v_count=0, clear_addr=0.
  - Framebuffer contents are not reset.
- Framebuffer:
  - 19200 words of 3 bits.
  - Address = y*160 + x, computed as {y,7'b0}+{y,5'b0}+x, 15 bits.
  - One write port and one registered read port (1-clock read latency).
- Write FSM, state RUN:
  - plot_en=1 with x<160 and y<120 writes colour at that clock.
  - plot_en=1 with x>=160 or y>=120 does not write; drop_count increments.
- Write FSM, state CLEAR:
  - BG_COLOUR is written to clear_addr every clock, and clear_addr increments.
  - When clear_addr=19199 is written, the next state is RUN and clear_addr returns to 0.
  - A clear takes exactly 19200 clocks.
  - plot_en=1 during CLEAR is dropped and drop_count increments.
  - clear_req during CLEAR is ignored (no restart).
- Transitions:
  - RUN -> CLEAR on clear_req=1.
  - If plot_en is asserted in the same clock as that clear_req, the plot is written first; busy rises the next clock.
  - Reset asserted mid-clear aborts the clear; after release, the clear restarts from address 0 (when CLEAR_ON_RESET=1).
- drop_count saturates at 255; it is cleared only by reset.
- Timing generator:
  - pix_tick toggles every clock; h_count/v_count advance on clocks where pix_tick=1.
  - h_count: 0..799, wraps to 0.
  - v_count: increments when h_count wraps; 0..524, wraps to 0.
- Scan-out pipeline:
  - Read address comes from (h_count>>2, v_count>>2) while h_count<640 and v_count<480; otherwise don't-care.
  - Read data is valid one clock after counters change.
  - On each pix_tick=1 clock, the output registers load the decode of the current counters:
    - vga_colour = visible ? read data : 0
    - vga_hs = !(656<=h<=751)
    - vga_vs = !(490<=v<=491)
    - vga_blank_n = (h<640 && v<480)
    - frame_start = (h==0 && v==0)
  - Outputs therefore lag the counters by one pixel (2 clocks) and are mutually aligned.
  - frame_start is high for exactly one clock per frame.
- Outputs hold between ticks.
- Read/write collision on the same address: the scan may show either old or new data; a write is never lost.
- Scan-out never stalls, including during CLEAR.

Test Plan:
- CLEAR_ON_RESET=1, reset for 3 clocks then release -> busy=1 for exactly 19200 clocks, then 0; every visible vga_colour=000 for the next frame.
- After clear, plot_en for 1 clock with x=5, y=3, colour=110 -> on screen h=20..23, v=12..15, vga_colour=110 with vga_blank_n=1; neighbouring pixels 000; drop_count=0.
- Plots (x=160,y=0,col=111) and (x=0,y=120,col=111), then 300 further out-of-range plots -> no framebuffer change; drop_count reads 2, then saturates at 255.
- Free run for 2 frames -> vga_hs low 192 clocks of every 1600; vga_vs low 3200 clocks of every 840000; frame_start pulses exactly 840000 clocks apart.
- Plot (10,10,011), then clear_req, then plot (11,10,101) 5 clocks later -> busy high 19200 clocks; second plot dropped (drop_count+1); afterwards both locations scan as BG_COLOUR.
- Reset asserted at clock 5000 of a clear -> outputs take reset values immediately; after release busy=1 for a full 19200 clocks again.
